// File: rtl/id_pipe_pkg.sv
// Shared decode constants, ALU encodings and the instruction decode function
// used by the registered decode stage.
package id_pipe_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_PREF    = 6'b110011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_SYNC = 6'b001111;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;

    localparam logic [4:0] NOP_REG_ADDR = 5'd0;

    typedef enum logic [7:0] {
        ALU_NOP = 8'b0000_0000,
        ALU_SRL = 8'b0000_0010,
        ALU_SRA = 8'b0000_0011,
        ALU_AND = 8'b0010_0100,
        ALU_OR  = 8'b0010_0101,
        ALU_XOR = 8'b0010_0110,
        ALU_NOR = 8'b0010_0111,
        ALU_SLL = 8'b0111_1100
    } aluop_e;

    typedef enum logic [2:0] {
        SEL_NOP   = 3'b000,
        SEL_LOGIC = 3'b001,
        SEL_SHIFT = 3'b010
    } alusel_e;

    typedef struct packed {
        logic        re1;
        logic        re2;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [4:0]  wd;
        logic        wreg;
        aluop_e      aluop;
        alusel_e     alusel;
        logic [31:0] imm1;
        logic [31:0] imm2;
        logic        illegal;
    } dec_t;

    function automatic dec_t id_decode(input logic [31:0] inst);
        dec_t d;
        logic rrr, shi, imm, lui, nop;
        d   = '0;
        rrr = 1'b0;
        shi = 1'b0;
        imm = 1'b0;
        lui = 1'b0;
        nop = 1'b0;
        if (inst[31:26] == OP_SPECIAL && inst[10:6] == 5'd0) begin
            case (inst[5:0])
                FN_AND:  begin d.aluop = ALU_AND; d.alusel = SEL_LOGIC; rrr = 1'b1; end
                FN_OR:   begin d.aluop = ALU_OR;  d.alusel = SEL_LOGIC; rrr = 1'b1; end
                FN_XOR:  begin d.aluop = ALU_XOR; d.alusel = SEL_LOGIC; rrr = 1'b1; end
                FN_NOR:  begin d.aluop = ALU_NOR; d.alusel = SEL_LOGIC; rrr = 1'b1; end
                FN_SLLV: begin d.aluop = ALU_SLL; d.alusel = SEL_SHIFT; rrr = 1'b1; end
                FN_SRLV: begin d.aluop = ALU_SRL; d.alusel = SEL_SHIFT; rrr = 1'b1; end
                FN_SRAV: begin d.aluop = ALU_SRA; d.alusel = SEL_SHIFT; rrr = 1'b1; end
                FN_SYNC: nop = 1'b1;
                default: ;
            endcase
        end
        // Immediate-shift forms require the rs field to be zero as well.
        if (inst[31:21] == 11'd0) begin
            case (inst[5:0])
                FN_SLL:  begin d.aluop = ALU_SLL; d.alusel = SEL_SHIFT; shi = 1'b1; end
                FN_SRL:  begin d.aluop = ALU_SRL; d.alusel = SEL_SHIFT; shi = 1'b1; end
                FN_SRA:  begin d.aluop = ALU_SRA; d.alusel = SEL_SHIFT; shi = 1'b1; end
                default: ;
            endcase
        end
        case (inst[31:26])
            OP_ORI:  begin d.aluop = ALU_OR;  d.alusel = SEL_LOGIC; imm = 1'b1; end
            OP_ANDI: begin d.aluop = ALU_AND; d.alusel = SEL_LOGIC; imm = 1'b1; end
            OP_XORI: begin d.aluop = ALU_XOR; d.alusel = SEL_LOGIC; imm = 1'b1; end
            OP_LUI:  begin d.aluop = ALU_OR;  d.alusel = SEL_LOGIC; lui = 1'b1; end
            OP_PREF: nop = 1'b1;
            default: ;
        endcase
        if (rrr) begin
            d.re1 = 1'b1; d.ra1 = inst[25:21];
            d.re2 = 1'b1; d.ra2 = inst[20:16];
            d.wd  = inst[15:11]; d.wreg = 1'b1;
        end
        if (shi) begin
            d.imm1 = {27'd0, inst[10:6]};
            d.re2  = 1'b1; d.ra2 = inst[20:16];
            d.wd   = inst[15:11]; d.wreg = 1'b1;
        end
        if (imm) begin
            d.re1  = 1'b1; d.ra1 = inst[25:21];
            d.imm2 = {16'd0, inst[15:0]};
            d.wd   = inst[20:16]; d.wreg = 1'b1;
        end
        if (lui) begin
            d.imm2 = {inst[15:0], 16'h0000};
            d.wd   = inst[20:16]; d.wreg = 1'b1;
        end
        d.illegal = !(rrr || shi || imm || lui || nop);
        if (d.wd == NOP_REG_ADDR) d.wreg = 1'b0;
        return d;
    endfunction

endpackage

// File: rtl/id_pipe_opnd_sel.sv
// Operand resolver: priority forwarding mux over NUM_FWD sources (index 0
// youngest) with detection of a pending (not-yet-available) selected source.
module id_opnd_sel #(
    parameter int NUM_FWD = 2,
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5
) (
    input  logic                      re_i,
    input  logic [REG_AW-1:0]         addr_i,
    input  logic [DATA_W-1:0]         rf_data_i,
    input  logic [DATA_W-1:0]         imm_i,
    input  logic [NUM_FWD-1:0]        fwd_wreg_i,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_wd_i,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
    input  logic [NUM_FWD-1:0]        fwd_pending_i,
    output logic [DATA_W-1:0]         data_o,
    output logic                      pend_o
);

    always_comb begin
        data_o = imm_i;
        pend_o = 1'b0;
        if (re_i) begin
            if (addr_i == '0) begin
                data_o = '0;
            end else begin
                data_o = rf_data_i;
                // Walk oldest to youngest so the lowest matching index wins.
                for (int i = NUM_FWD - 1; i >= 0; i--) begin
                    if (fwd_wreg_i[i] && fwd_wd_i[i*REG_AW +: REG_AW] == addr_i) begin
                        data_o = fwd_wdata_i[i*DATA_W +: DATA_W];
                        pend_o = fwd_pending_i[i];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/id_pipe.sv
// Registered decode stage: D register with decode and operand forwarding,
// load-use interlock, and a handshaked E register feeding EX.
module id_pipe
    import id_pipe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int REG_AW   = 5,
    parameter int NUM_FWD  = 2,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3,
    parameter int STALL_CW = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADDR_W-1:0]         pc_i,
    input  logic [31:0]               inst_i,
    output logic                      reg1_read_o,
    output logic                      reg2_read_o,
    output logic [REG_AW-1:0]         reg1_addr_o,
    output logic [REG_AW-1:0]         reg2_addr_o,
    input  logic [DATA_W-1:0]         reg1_data_i,
    input  logic [DATA_W-1:0]         reg2_data_i,
    input  logic [NUM_FWD-1:0]        fwd_wreg_i,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_wd_i,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
    input  logic [NUM_FWD-1:0]        fwd_pending_i,
    input  logic                      flush_i,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_W-1:0]         pc_o,
    output logic [ALUOP_W-1:0]        aluop_o,
    output logic [ALUSEL_W-1:0]       alusel_o,
    output logic [DATA_W-1:0]         reg1_o,
    output logic [DATA_W-1:0]         reg2_o,
    output logic [REG_AW-1:0]         wd_o,
    output logic                      wreg_o,
    output logic                      illegal_o,
    output logic [STALL_CW-1:0]       stall_cnt_o
);

    logic                d_valid_q, d_valid_d;
    logic [ADDR_W-1:0]   d_pc_q, d_pc_d;
    logic [31:0]         d_inst_q, d_inst_d;

    logic                e_valid_q, e_valid_d;
    logic [ADDR_W-1:0]   e_pc_q, e_pc_d;
    logic [ALUOP_W-1:0]  e_aluop_q, e_aluop_d;
    logic [ALUSEL_W-1:0] e_alusel_q, e_alusel_d;
    logic [DATA_W-1:0]   e_reg1_q, e_reg1_d;
    logic [DATA_W-1:0]   e_reg2_q, e_reg2_d;
    logic [REG_AW-1:0]   e_wd_q, e_wd_d;
    logic                e_wreg_q, e_wreg_d;
    logic                e_illegal_q, e_illegal_d;
    logic [STALL_CW-1:0] stall_q, stall_d;

    dec_t                dec;
    logic [DATA_W-1:0]   opnd1, opnd2;
    logic                pend1, pend2;
    logic                hazard, d_adv;

    assign dec = id_decode(d_inst_q);

    // Read ports are only live while D holds an instruction.
    assign reg1_read_o = d_valid_q && dec.re1;
    assign reg2_read_o = d_valid_q && dec.re2;
    assign reg1_addr_o = d_valid_q ? REG_AW'(dec.ra1) : '0;
    assign reg2_addr_o = d_valid_q ? REG_AW'(dec.ra2) : '0;

    id_opnd_sel #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W), .REG_AW(REG_AW)) u_opnd1 (
        .re_i          (reg1_read_o),
        .addr_i        (reg1_addr_o),
        .rf_data_i     (reg1_data_i),
        .imm_i         (DATA_W'(dec.imm1)),
        .fwd_wreg_i    (fwd_wreg_i),
        .fwd_wd_i      (fwd_wd_i),
        .fwd_wdata_i   (fwd_wdata_i),
        .fwd_pending_i (fwd_pending_i),
        .data_o        (opnd1),
        .pend_o        (pend1)
    );

    id_opnd_sel #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W), .REG_AW(REG_AW)) u_opnd2 (
        .re_i          (reg2_read_o),
        .addr_i        (reg2_addr_o),
        .rf_data_i     (reg2_data_i),
        .imm_i         (DATA_W'(dec.imm2)),
        .fwd_wreg_i    (fwd_wreg_i),
        .fwd_wd_i      (fwd_wd_i),
        .fwd_wdata_i   (fwd_wdata_i),
        .fwd_pending_i (fwd_pending_i),
        .data_o        (opnd2),
        .pend_o        (pend2)
    );

    assign hazard   = pend1 || pend2;
    assign d_adv    = d_valid_q && !hazard && (!e_valid_q || out_ready);
    assign in_ready = !d_valid_q || d_adv;

    always_comb begin
        d_valid_d   = d_valid_q;
        d_pc_d      = d_pc_q;
        d_inst_d    = d_inst_q;
        e_valid_d   = e_valid_q;
        e_pc_d      = e_pc_q;
        e_aluop_d   = e_aluop_q;
        e_alusel_d  = e_alusel_q;
        e_reg1_d    = e_reg1_q;
        e_reg2_d    = e_reg2_q;
        e_wd_d      = e_wd_q;
        e_wreg_d    = e_wreg_q;
        e_illegal_d = e_illegal_q;
        stall_d     = stall_q;

        if (d_adv) d_valid_d = 1'b0;
        if (in_valid && in_ready) begin
            d_valid_d = 1'b1;
            d_pc_d    = pc_i;
            d_inst_d  = inst_i;
        end

        if (d_adv) begin
            e_valid_d   = 1'b1;
            e_pc_d      = d_pc_q;
            e_aluop_d   = ALUOP_W'(dec.aluop);
            e_alusel_d  = ALUSEL_W'(dec.alusel);
            e_reg1_d    = opnd1;
            e_reg2_d    = opnd2;
            e_wd_d      = REG_AW'(dec.wd);
            e_wreg_d    = dec.wreg;
            e_illegal_d = dec.illegal;
        end else if (out_ready) begin
            e_valid_d = 1'b0;
        end

        // Flush drops both stages but leaves the stall statistic intact.
        if (flush_i) begin
            d_valid_d = 1'b0;
            e_valid_d = 1'b0;
        end

        if (d_valid_q && hazard && stall_q != '1) stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            d_valid_q   <= 1'b0;
            d_pc_q      <= '0;
            d_inst_q    <= '0;
            e_valid_q   <= 1'b0;
            e_pc_q      <= '0;
            e_aluop_q   <= ALUOP_W'(ALU_NOP);
            e_alusel_q  <= ALUSEL_W'(SEL_NOP);
            e_reg1_q    <= '0;
            e_reg2_q    <= '0;
            e_wd_q      <= '0;
            e_wreg_q    <= 1'b0;
            e_illegal_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            d_valid_q   <= d_valid_d;
            d_pc_q      <= d_pc_d;
            d_inst_q    <= d_inst_d;
            e_valid_q   <= e_valid_d;
            e_pc_q      <= e_pc_d;
            e_aluop_q   <= e_aluop_d;
            e_alusel_q  <= e_alusel_d;
            e_reg1_q    <= e_reg1_d;
            e_reg2_q    <= e_reg2_d;
            e_wd_q      <= e_wd_d;
            e_wreg_q    <= e_wreg_d;
            e_illegal_q <= e_illegal_d;
            stall_q     <= stall_d;
        end
    end

    assign out_valid   = e_valid_q;
    assign pc_o        = e_pc_q;
    assign aluop_o     = e_aluop_q;
    assign alusel_o    = e_alusel_q;
    assign reg1_o      = e_reg1_q;
    assign reg2_o      = e_reg2_q;
    assign wd_o        = e_wd_q;
    assign wreg_o      = e_wreg_q;
    assign illegal_o   = e_illegal_q;
    assign stall_cnt_o = stall_q;

endmodule
